// File: rtl/cc_down_counter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | cc_down_counter: loadable down-counter with Moore busy/done flags.        |
// | Optional: CC_DOWNCOUNTER_AUTORELOAD_EN restarts from the last load value.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module cc_down_counter #(
  parameter int DOWNCOUNTER_DATAWIDTH = 3
) (
  input  logic                             CC_DOWNCOUNTER_CLOCK_50,
  input  logic                             CC_DOWNCOUNTER_RESET_InLow,
  input  logic                             CC_DOWNCOUNTER_load_InHigh,
  input  logic [DOWNCOUNTER_DATAWIDTH-1:0] CC_DOWNCOUNTER_data_InBUS,
  input  logic                             CC_DOWNCOUNTER_tick_InHigh,
  input  logic                             CC_DOWNCOUNTER_pause_InHigh,
  output logic [DOWNCOUNTER_DATAWIDTH-1:0] CC_DOWNCOUNTER_data_OutBUS,
  output logic                             CC_DOWNCOUNTER_busy_OutHigh,
  output logic                             CC_DOWNCOUNTER_done_OutHigh
);

  localparam logic [DOWNCOUNTER_DATAWIDTH-1:0] C_ZERO = '0;
  localparam logic [DOWNCOUNTER_DATAWIDTH-1:0] C_ONE  = {{(DOWNCOUNTER_DATAWIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                           state_q, state_d;
  logic [DOWNCOUNTER_DATAWIDTH-1:0] count_q, count_d;

`ifdef CC_DOWNCOUNTER_AUTORELOAD_EN
  logic [DOWNCOUNTER_DATAWIDTH-1:0] reload_q, reload_d;

  always_ff @(posedge CC_DOWNCOUNTER_CLOCK_50 or negedge CC_DOWNCOUNTER_RESET_InLow) begin
    if (!CC_DOWNCOUNTER_RESET_InLow) begin
      reload_q <= C_ZERO;
    end else begin
      reload_q <= reload_d;
    end
  end

  always_comb begin
    reload_d = reload_q;
    if (CC_DOWNCOUNTER_load_InHigh) begin
      reload_d = CC_DOWNCOUNTER_data_InBUS;
    end
  end
`endif

  always_ff @(posedge CC_DOWNCOUNTER_CLOCK_50 or negedge CC_DOWNCOUNTER_RESET_InLow) begin
    if (!CC_DOWNCOUNTER_RESET_InLow) begin
      state_q <= S_IDLE;
      count_q <= C_ZERO;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (CC_DOWNCOUNTER_load_InHigh) begin
      // Load beats everything, including the final tick and a pending DONE.
      count_d = CC_DOWNCOUNTER_data_InBUS;
      state_d = (CC_DOWNCOUNTER_data_InBUS != C_ZERO) ? S_RUN : S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_RUN: begin
          if (CC_DOWNCOUNTER_tick_InHigh && !CC_DOWNCOUNTER_pause_InHigh) begin
            if (count_q > C_ONE) begin
              count_d = count_q - C_ONE;
            end else begin
              count_d = C_ZERO;
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
`ifdef CC_DOWNCOUNTER_AUTORELOAD_EN
          if (reload_q != C_ZERO) begin
            count_d = reload_q;
            state_d = S_RUN;
          end else begin
            count_d = C_ZERO;
            state_d = S_IDLE;
          end
`else
          count_d = C_ZERO;
          state_d = S_IDLE;
`endif
        end
        default: begin
          count_d = C_ZERO;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign CC_DOWNCOUNTER_data_OutBUS  = count_q;
  assign CC_DOWNCOUNTER_busy_OutHigh = (state_q == S_RUN);
  assign CC_DOWNCOUNTER_done_OutHigh = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_cc_down_counter.sv
`default_nettype none
// Bench for cc_down_counter: directed cases with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_cc_down_counter;

  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic         load;
  logic [W-1:0] data;
  logic         tick;
  logic         pause;
  logic [W-1:0] q_bus;
  logic         q_busy;
  logic         q_done;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 0;

  cc_down_counter #(.DOWNCOUNTER_DATAWIDTH(W)) dut (
    .CC_DOWNCOUNTER_CLOCK_50    (clk),
    .CC_DOWNCOUNTER_RESET_InLow (rst_n),
    .CC_DOWNCOUNTER_load_InHigh (load),
    .CC_DOWNCOUNTER_data_InBUS  (data),
    .CC_DOWNCOUNTER_tick_InHigh (tick),
    .CC_DOWNCOUNTER_pause_InHigh(pause),
    .CC_DOWNCOUNTER_data_OutBUS (q_bus),
    .CC_DOWNCOUNTER_busy_OutHigh(q_busy),
    .CC_DOWNCOUNTER_done_OutHigh(q_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining ticks, whether a countdown is live, and
  // whether the countdown expired on the previous edge.
  int m_count  = 0;
  int m_reload = 0;
  bit m_busy   = 0;
  bit m_done   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count = 0; m_reload = 0; m_busy = 0; m_done = 0;
    end else if (load) begin
      m_count  = int'(data);
      m_reload = int'(data);
      m_busy   = (data != 0);
      m_done   = 0;
    end else if (m_busy) begin
      if (tick && !pause) begin
        m_count = m_count - 1;
        if (m_count == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end else if (m_done) begin
      m_done = 0;
`ifdef CC_DOWNCOUNTER_AUTORELOAD_EN
      if (m_reload != 0) begin
        m_count = m_reload;
        m_busy  = 1;
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_bus",  int'(q_bus),  m_count);
      check("model_busy", int'(q_busy), int'(m_busy));
      check("model_done", int'(q_done), int'(m_done));
    end
  end

  // Apply inputs at a falling edge, let one rising edge pass, return at the
  // next falling edge with the post-edge outputs settled.
  task automatic cyc(input bit l, input int d, input bit t, input bit p);
    load  = l;
    data  = W'(d);
    tick  = t;
    pause = p;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect3(input string name, input int b, input int bz, input int dn);
    check({name, "_bus"},  int'(q_bus),  b);
    check({name, "_busy"}, int'(q_busy), bz);
    check({name, "_done"}, int'(q_done), dn);
  endtask

  initial begin
    int exp_seq[7];
    rst_n = 1'b0; load = 0; data = '0; tick = 0; pause = 0;
    repeat (2) @(negedge clk);
    expect3("reset", 0, 0, 0);
    rst_n = 1'b1;
    cmp_en = 1;
    @(negedge clk);

    // Basic countdown from 3
    cyc(1, 3, 0, 0); expect3("basic_load", 3, 1, 0);
    cyc(0, 0, 1, 0); expect3("basic_t1", 2, 1, 0);
    cyc(0, 0, 1, 0); expect3("basic_t2", 1, 1, 0);
    cyc(0, 0, 1, 0); expect3("basic_t3", 0, 0, 1);
    cyc(0, 0, 1, 0);
`ifdef CC_DOWNCOUNTER_AUTORELOAD_EN
    expect3("basic_after", 3, 1, 0);
    cyc(0, 0, 1, 0); expect3("reload_t1", 2, 1, 0);
    cyc(0, 0, 1, 0); expect3("reload_t2", 1, 1, 0);
    cyc(0, 0, 1, 0); expect3("reload_t3", 0, 0, 1);
    cyc(1, 0, 1, 0); expect3("reload_stop", 0, 0, 0);
`else
    expect3("basic_after", 0, 0, 0);
`endif

    // Pause gating: 4,3,3,3,2,1,0
    exp_seq = '{4, 3, 3, 3, 2, 1, 0};
    cyc(1, 4, 0, 0); check("pause_s0", int'(q_bus), exp_seq[0]);
    cyc(0, 0, 1, 0); check("pause_s1", int'(q_bus), exp_seq[1]);
    cyc(0, 0, 1, 1); check("pause_s2", int'(q_bus), exp_seq[2]);
    cyc(0, 0, 1, 1); check("pause_s3", int'(q_bus), exp_seq[3]);
    cyc(0, 0, 1, 0); check("pause_s4", int'(q_bus), exp_seq[4]);
    cyc(0, 0, 1, 0); check("pause_s5", int'(q_bus), exp_seq[5]);
    cyc(0, 0, 1, 0); expect3("pause_s6", exp_seq[6], 0, 1);
    cyc(1, 0, 0, 0); expect3("zero_load", 0, 0, 0);
    cyc(0, 0, 1, 0); expect3("zero_hold", 0, 0, 0);

    // Full-scale load: seven ticks to expiry
    cyc(1, 7, 0, 0); expect3("full_load", 7, 1, 0);
    for (int i = 1; i <= 6; i++) cyc(0, 0, 1, 0);
    expect3("full_t6", 1, 1, 0);
    cyc(0, 0, 1, 0); expect3("full_t7", 0, 0, 1);
    cyc(1, 0, 1, 0); expect3("full_idle", 0, 0, 0);
    cyc(0, 0, 1, 0); expect3("full_nowrap", 0, 0, 0);

    // Load collides with the final tick, then load during DONE
    cyc(1, 2, 0, 0);
    cyc(0, 0, 1, 0); expect3("prio_at1", 1, 1, 0);
    cyc(1, 6, 1, 0); expect3("prio_load", 6, 1, 0);
    for (int i = 1; i <= 6; i++) cyc(0, 0, 1, 0);
    expect3("prio_done", 0, 0, 1);
    cyc(1, 2, 0, 0); expect3("done_load", 2, 1, 0);

    // Asynchronous reset mid-count
    cyc(1, 5, 0, 0); expect3("rst_pre", 5, 1, 0);
    load = 0; tick = 1;
    #2 rst_n = 1'b0;
    #1 expect3("rst_async", 0, 0, 0);
    @(negedge clk);
    expect3("rst_hold", 0, 0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 1, 0); expect3("rst_idle", 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 7) == 0), int'($urandom_range(0, 7)),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
    end

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
